// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   localparam int unsigned REG_ADDR_W    = 5;
   localparam int unsigned PipeDepthDef  = 5;
   localparam int unsigned MemTimeoutDef = 16;

   typedef enum logic [1:0] {
      StRun,
      StMemWait,
      StDrain,
      StHalted
   } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath (master) and the stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
);
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_uses_rs1;
   logic                  id_uses_rs2;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_is_load;
   logic                  ex_reg_wr;
   logic                  ex_br_taken;
   logic                  mem_req;
   logic                  mem_ready;
   logic                  halt_req;

   logic                  pc_en;
   logic                  ifid_en;
   logic                  ifid_flush;
   logic                  idex_flush;
   logic                  exmem_en;
   logic                  memwb_flush;
   logic                  halted;
   logic                  mem_err;
   logic [CNT_W-1:0]      stall_cnt;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, ex_reg_wr,
             ex_br_taken, mem_req, mem_ready, halt_req,
      input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush, halted,
             mem_err, stall_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, ex_reg_wr,
             ex_br_taken, mem_req, mem_ready, halt_req,
      output pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush, halted,
             mem_err, stall_cnt
   );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: decode reads a register an in-flight load will write.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_uses_rs1_i,
   input  logic                  id_uses_rs2_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  ex_is_load_i,
   input  logic                  ex_reg_wr_i,
   output logic                  lu_o
);

   logic rs1_hit, rs2_hit;

   assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
   // x0 is hard-wired zero, so a load targeting it never creates a dependency
   assign lu_o    = ex_is_load_i && ex_reg_wr_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, branch flush, load-use bubble,
// debug drain/halt, with a memory-timeout error flag and a saturating stall counter.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned PIPE_DEPTH  = PipeDepthDef,
   parameter int unsigned MEM_TIMEOUT = MemTimeoutDef,
   parameter int unsigned CNT_W       = 32
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int unsigned DrainW = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
   localparam int unsigned WaitW  = $clog2(MEM_TIMEOUT + 1);

   hz_state_e         state_q, state_d, ret_q, ret_d;
   logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
   logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
   logic              mem_err_q, mem_err_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic lu, freeze;
   logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush;

   load_use_detect u_load_use_detect (
      .id_rs1_i      (hz.id_rs1),
      .id_rs2_i      (hz.id_rs2),
      .id_uses_rs1_i (hz.id_uses_rs1),
      .id_uses_rs2_i (hz.id_uses_rs2),
      .ex_rd_i       (hz.ex_rd),
      .ex_is_load_i  (hz.ex_is_load),
      .ex_reg_wr_i   (hz.ex_reg_wr),
      .lu_o          (lu)
   );

   assign freeze = hz.mem_req && !hz.mem_ready;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b1;
      memwb_flush = 1'b0;
      if (state_q == StHalted) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (freeze) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
      end else if (hz.ex_br_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (lu) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (state_q == StDrain) begin
         // Draining: stop fetching and push bubbles behind the last real instruction
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      drain_cnt_d = drain_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      mem_err_d   = mem_err_q;
      stall_cnt_d = stall_cnt_q;
      case (state_q)
         StRun, StDrain: begin
            if (freeze) begin
               // The first frozen cycle counts towards the timeout
               state_d    = StMemWait;
               ret_d      = state_q;
               wait_cnt_d = WaitW'(1);
            end else if (state_q == StRun) begin
               if (!hz.ex_br_taken && !lu && hz.halt_req) begin
                  state_d     = StDrain;
                  drain_cnt_d = DrainW'(PIPE_DEPTH - 2);
               end
            end else if (hz.ex_br_taken || !lu) begin
               if (drain_cnt_q == '0) begin
                  state_d = StHalted;
               end else begin
                  drain_cnt_d = drain_cnt_q - 1'b1;
               end
            end
         end
         StMemWait: begin
            if (!freeze) begin
               wait_cnt_d = '0;
               state_d    = ret_q;
            end else if (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1)) begin
               wait_cnt_d = '0;
               mem_err_d  = 1'b1;
               state_d    = StHalted;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         StHalted: begin
            if (!hz.halt_req && !mem_err_q) state_d = StRun;
         end
         default: state_d = StRun;
      endcase
      if ((!pc_en || ifid_flush) && (state_q != StHalted) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StRun;
         ret_q       <= StRun;
         drain_cnt_q <= '0;
         wait_cnt_q  <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         drain_cnt_q <= drain_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Buffer controls go quiet the moment reset asserts, independent of the clock
   assign hz.pc_en       = pc_en & ~rst;
   assign hz.ifid_en     = ifid_en & ~rst;
   assign hz.ifid_flush  = ifid_flush & ~rst;
   assign hz.idex_flush  = idex_flush & ~rst;
   assign hz.exmem_en    = exmem_en & ~rst;
   assign hz.memwb_flush = memwb_flush & ~rst;
   assign hz.halted      = (state_q == StHalted);
   assign hz.mem_err     = mem_err_q;
   assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic checked
// against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned PD = 5;
   localparam int unsigned MT = 16;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       u1;
      logic       u2;
      logic       ld;
      logic       wr;
      logic       br;
      logic       mreq;
      logic       mrdy;
      logic       halt;
      logic       rst;
   } stim_t;

   // ctl = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush, halted, mem_err}
   typedef struct packed {
      logic [7:0]  ctl;
      logic [31:0] stall;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pipeline_hazard_ctrl_if #(.CNT_W(32)) hz ();

   pipeline_hazard_ctrl #(
      .PIPE_DEPTH  (PD),
      .MEM_TIMEOUT (MT),
      .CNT_W       (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   // Reference model: pipeline "situation" kept as plain flags and counters
   bit          m_halted, m_err, m_waiting;
   int          m_waited;
   int          m_drain_left;  // -1 when no drain is in progress
   longint      m_stalls;
   bit          halt_lvl;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check("ctl", {56'd0, hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_flush, hz.exmem_en,
                       hz.memwb_flush, hz.halted, hz.mem_err}, {56'd0, mon_e.ctl});
         check("stall_cnt", {32'd0, hz.stall_cnt}, {32'd0, mon_e.stall});
      end
   end

   task automatic model_reset();
      m_halted     = 1'b0;
      m_err        = 1'b0;
      m_waiting    = 1'b0;
      m_waited     = 0;
      m_drain_left = -1;
      m_stalls     = 0;
   endtask

   task automatic apply(input stim_t s);
      hz.id_rs1      = s.rs1;
      hz.id_rs2      = s.rs2;
      hz.ex_rd       = s.rd;
      hz.id_uses_rs1 = s.u1;
      hz.id_uses_rs2 = s.u2;
      hz.ex_is_load  = s.ld;
      hz.ex_reg_wr   = s.wr;
      hz.ex_br_taken = s.br;
      hz.mem_req     = s.mreq;
      hz.mem_ready   = s.mrdy;
      hz.halt_req    = s.halt;
      rst            = s.rst;
   endtask

   // One clock cycle: drive inputs, push what the outputs must be, advance the model.
   task automatic step(input stim_t s);
      bit   fz, lu;
      bit   pc, ie, ifl, idl, ee, mwf;
      exp_t e;
      @(posedge clk);
      #1;
      apply(s);
      if (s.rst) begin
         model_reset();
         e.ctl   = 8'b0;
         e.stall = 32'd0;
         sb_q.push_back(e);
         return;
      end
      fz = s.mreq && !s.mrdy;
      lu = s.ld && s.wr && (s.rd != 5'd0) &&
           ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
      pc = 1; ie = 1; ifl = 0; idl = 0; ee = 1; mwf = 0;
      if (m_halted) begin
         pc = 0; ie = 0; idl = 1;
      end else if (fz) begin
         pc = 0; ie = 0; ee = 0; mwf = 1;
      end else if (s.br) begin
         ifl = 1; idl = 1;
      end else if (lu) begin
         pc = 0; ie = 0; idl = 1;
      end else if (m_drain_left >= 0 && !m_waiting) begin
         pc = 0; ifl = 1;
      end
      e.ctl   = {pc, ie, ifl, idl, ee, mwf, m_halted, m_err};
      e.stall = m_stalls[31:0];
      sb_q.push_back(e);

      if (!m_halted && (!pc || ifl) && m_stalls < 64'hFFFF_FFFF) m_stalls++;

      if (m_halted) begin
         if (!s.halt && !m_err) m_halted = 0;
      end else if (m_waiting) begin
         if (!fz) begin
            m_waiting = 0;
         end else if (m_waited + 1 >= MT) begin
            m_err        = 1;
            m_halted     = 1;
            m_waiting    = 0;
            m_drain_left = -1;
         end else begin
            m_waited++;
         end
      end else if (fz) begin
         m_waiting = 1;
         m_waited  = 1;
      end else if (m_drain_left >= 0) begin
         if (s.br || !lu) begin
            if (m_drain_left == 0) begin
               m_halted     = 1;
               m_drain_left = -1;
            end else begin
               m_drain_left--;
            end
         end
      end else if (!s.br && !lu && s.halt) begin
         m_drain_left = PD - 2;
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t lu_stim(input logic [4:0] rd);
      stim_t s;
      s     = '0;
      s.ld  = 1; s.wr = 1; s.rd = rd; s.u1 = 1; s.rs1 = 5'd5;
      return s;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      model_reset();
      halt_lvl = 0;
      apply(idle() | stim_t'(1));  // rst = 1, everything else 0

      s = idle(); s.rst = 1;
      step(s); step(s);
      step(idle());

      // Load-use bubble, then the same with rd = x0
      step(lu_stim(5'd5)); step(idle());
      step(lu_stim(5'd0)); step(idle());

      // Branch together with the hazard
      s = lu_stim(5'd5); s.br = 1;
      step(s); step(idle());

      // Three frozen cycles then completion
      s = idle(); s.mreq = 1;
      repeat (3) step(s);
      s.mrdy = 1;
      step(s); step(idle()); step(idle());

      // Timeout: sixteen frozen cycles, halted stays until reset
      s = idle(); s.mreq = 1;
      repeat (MT) step(s);
      repeat (3) step(idle());
      s = idle(); s.rst = 1;
      step(s);
      step(idle());

      // Drain with a load-use in the first drain cycle, then release
      s = idle(); s.halt = 1;
      step(s);
      s = lu_stim(5'd5); s.halt = 1;
      step(s);
      s = idle(); s.halt = 1;
      repeat (6) step(s);
      repeat (3) step(idle());

      // Asynchronous reset while waiting on memory
      step(lu_stim(5'd5));
      s = idle(); s.mreq = 1;
      step(s);
      @(posedge clk);
      #1;
      apply(s);
      #1 rst = 1'b1;
      #1;
      check("async_rst_ctl", {56'd0, hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_flush,
                              hz.exmem_en, hz.memwb_flush, hz.halted, hz.mem_err}, 64'd0);
      check("async_rst_stall", {32'd0, hz.stall_cnt}, 64'd0);
      model_reset();
      s = idle(); s.rst = 1;
      step(s);
      step(idle());

      // Randomized traffic, normal then memory-starved
      for (int phase = 0; phase < 2; phase++) begin
         for (int i = 0; i < 2500; i++) begin
            s.rs1  = 5'($urandom_range(0, 3));
            s.rs2  = 5'($urandom_range(0, 3));
            s.rd   = 5'($urandom_range(0, 3));
            s.u1   = 1'($urandom_range(0, 1));
            s.u2   = 1'($urandom_range(0, 1));
            s.ld   = ($urandom_range(0, 2) == 0);
            s.wr   = ($urandom_range(0, 3) != 0);
            s.br   = ($urandom_range(0, 6) == 0);
            if (phase == 0) begin
               s.mreq = ($urandom_range(0, 4) == 0);
               s.mrdy = ($urandom_range(0, 2) != 0);
            end else begin
               s.mreq = ($urandom_range(0, 9) != 0);
               s.mrdy = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 30) == 0) halt_lvl = !halt_lvl;
            s.halt = halt_lvl;
            s.rst  = ($urandom_range(0, 150) == 0);
            step(s);
         end
      end

      step(idle());
      @(negedge clk);
      #1;
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
